// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic {
    F_NEW,
    F_WAIT
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_out_slot.sv
// One-entry valid/ready register between fetch and decode.
// A flush empties the slot and wins over a fill on the same edge.
module fetch_out_slot
  import fetch_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         fill,
  input  logic         flush,
  input  logic         decode_ready,
  input  logic [W-1:0] fill_instr,
  input  logic [W-1:0] fill_pc,
  output logic         instr_valid,
  output logic [W-1:0] instr,
  output logic [W-1:0] instr_pc,
  output logic         drain
);

  logic         valid_q, valid_d;
  logic [W-1:0] instr_q, instr_d;
  logic [W-1:0] pc_q, pc_d;

  assign drain = valid_q & decode_ready;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (fill) begin
      valid_d = 1'b1;
      instr_d = fill_instr;
      pc_d    = fill_pc;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign instr_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, waits out ICache stalls, and hands words to decode.
// Redirects from downstream override everything and flush the output slot.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] icache_addr,
  input  logic [XLEN-1:0] icache_data,
  input  logic            icache_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            decode_ready,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic            slot_free;
  logic            capture;
  logic            drain;

  assign slot_free = ~instr_valid | decode_ready;

  // The cycle right after a new address is never trusted: the ICache has not yet raised its stall.
  assign capture = (state_q == F_WAIT) & ~icache_stall & slot_free & ~redirect_valid;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    unique case (state_q)
      F_NEW:  state_d = F_WAIT;
      F_WAIT: begin
        if (capture) begin
          pc_d    = pc_q + XLEN'(INSTR_BYTES);
          state_d = F_NEW;
        end
      end
      default: state_d = F_NEW;
    endcase
    if (redirect_valid) begin
      pc_d    = align_pc(redirect_pc);
      state_d = F_NEW;
    end
    if (drain) begin
      fetch_count_d = fetch_count_q + XLEN'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= F_NEW;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  fetch_out_slot #(.W(XLEN)) u_out_slot (
    .clock        (clock),
    .reset        (reset),
    .fill         (capture),
    .flush        (redirect_valid),
    .decode_ready (decode_ready),
    .fill_instr   (icache_data),
    .fill_pc      (pc_q),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .drain        (drain)
  );

  assign icache_addr = pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a stalling ICache model plus a
// transaction-level scoreboard of the in-order word stream decode should see.
module tb_fetch_stage;

   localparam int IDLE_LIMIT = 12;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] icache_addr;
   logic [31:0] icache_data;
   logic        icache_stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        decode_ready;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] fetch_count;

   int          total_cnt = 0;
   int          bad_cnt = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_count;
   int          idle_cycles;
   int          cache_lat;
   int          guard;

   logic [31:0] cache_addr_q;
   logic        cache_stall_q;
   int          cache_cnt;

   always #5 clock = ~clock;

   fetch_stage #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
      .clock          (clock),
      .reset          (reset),
      .icache_addr    (icache_addr),
      .icache_data    (icache_data),
      .icache_stall   (icache_stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .decode_ready   (decode_ready),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .fetch_count    (fetch_count)
   );

   // Memory contents are a fixed function of the address, so word zero reads as zero.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:0], a[31:8]};
   endfunction

   // ICache model: stall rises one edge after a new address, lasts cache_lat cycles,
   // and the data bus carries garbage whenever the word is not yet valid.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         cache_addr_q  <= 32'hFFFF_FFFF;
         cache_stall_q <= 1'b0;
         cache_cnt     <= 0;
      end else if (icache_addr != cache_addr_q) begin
         cache_addr_q  <= icache_addr;
         cache_stall_q <= 1'b1;
         cache_cnt     <= cache_lat - 1;
      end else if (cache_cnt > 0) begin
         cache_cnt <= cache_cnt - 1;
      end else begin
         cache_stall_q <= 1'b0;
      end
   end

   assign icache_stall = cache_stall_q;
   assign icache_data  = (icache_addr == cache_addr_q && !cache_stall_q) ?
                         mem_word(icache_addr) : 32'hDEAD_BEEF;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      total_cnt++;
      if (got !== want) begin
         bad_cnt++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, want);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, advance the scoreboard,
   // then check the post-edge state and return at the next falling edge.
   task automatic applyStimulus(input logic rdy, input logic rv, input logic [31:0] rpc);
      decode_ready   = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      if (instr_valid) begin
         checkOutput("slot_pc", instr_pc, exp_pc);
         checkOutput("slot_instr", instr, mem_word(exp_pc));
      end
      if (instr_valid && rdy) begin
         exp_pc    = exp_pc + 32'd4;
         exp_count = exp_count + 32'd1;
      end
      if (rv) exp_pc = {rpc[31:2], 2'b00};
      @(posedge clock);
      #1;
      checkOutput("fetch_count", fetch_count, exp_count);
      if (rv) checkOutput("flush_valid", 32'(instr_valid), 32'd0);
      if (instr_valid || rv) idle_cycles = 0;
      else idle_cycles++;
      checkOutput("watchdog", 32'(idle_cycles > IDLE_LIMIT), 32'd0);
      @(negedge clock);
   endtask

   task automatic resetDut();
      reset          = 1'b1;
      decode_ready   = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      cache_lat      = 5;
      repeat (2) @(negedge clock);
      reset       = 1'b0;
      exp_pc      = 32'd0;
      exp_count   = 32'd0;
      idle_cycles = 0;
   endtask

   initial begin
      reset          = 1'b1;
      decode_ready   = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      cache_lat      = 5;
      @(negedge clock);
      #1;
      checkOutput("rst_icache_addr", icache_addr, 32'd0);
      checkOutput("rst_valid", 32'(instr_valid), 32'd0);
      checkOutput("rst_instr", instr, 32'd0);
      checkOutput("rst_instr_pc", instr_pc, 32'd0);
      checkOutput("rst_count", fetch_count, 32'd0);
      resetDut();

      // First word latency with a 5-cycle ICache, decode holding off.
      guard = 0;
      while (!instr_valid && guard < 30) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         guard++;
      end
      checkOutput("first_valid_edges", 32'(guard), 32'd7);
      checkOutput("first_instr", instr, 32'd0);
      checkOutput("first_instr_pc", instr_pc, 32'd0);

      // Backpressure: the held word stays put and the PC waits on the next address.
      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         checkOutput("bp_addr", icache_addr, 32'd4);
         checkOutput("bp_instr_pc", instr_pc, 32'd0);
      end
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("bp_refill_valid", 32'(instr_valid), 32'd1);
      checkOutput("bp_refill_pc", instr_pc, 32'd4);
      checkOutput("bp_refill_instr", instr, mem_word(32'd4));

      // Steady ready: the sequence continues without gaps.
      guard = 0;
      while (exp_count < 32'd4 && guard < 60) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         guard++;
      end
      checkOutput("count4", fetch_count, 32'd4);

      // Redirect while the ICache is stalled on address 8.
      resetDut();
      guard = 0;
      while (!(icache_addr == 32'd8 && icache_stall) && guard < 80) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         guard++;
      end
      checkOutput("wait_addr8", icache_addr, 32'd8);
      applyStimulus(1'b1, 1'b1, 32'h0000_0101);
      checkOutput("redir_addr", icache_addr, 32'h0000_0100);
      guard = 0;
      while (!instr_valid && guard < 30) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         guard++;
      end
      checkOutput("redir_first_pc", instr_pc, 32'h0000_0100);

      // Redirect in the very cycle a capture would happen, to the top of memory.
      guard = 0;
      while (!(icache_addr == cache_addr_q && !icache_stall) && guard < 30) begin
         applyStimulus(1'b1, 1'b0, 32'd0);
         guard++;
      end
      checkOutput("wait_capture", 32'(icache_addr == cache_addr_q && !icache_stall), 32'd1);
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFC);
      checkOutput("cap_redir_addr", icache_addr, 32'hFFFF_FFFC);
      guard = 0;
      while (!instr_valid && guard < 30) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         guard++;
      end
      checkOutput("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
      checkOutput("wrap_addr", icache_addr, 32'd0);

      // Randomized traffic: random ready, ICache latency and occasional redirects.
      for (int i = 0; i < 800; i++) begin
         logic        rv;
         logic [31:0] rpc;
         cache_lat = int'($urandom_range(1, 5));
         rv        = ($urandom_range(0, 24) == 0);
         rpc       = $urandom;
         if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000F);
         applyStimulus(($urandom_range(0, 9) < 7), rv, rpc);
      end

      // Asynchronous reset in the middle of a stall with a word held in the slot.
      cache_lat = 5;
      applyStimulus(1'b0, 1'b1, 32'h0000_0040);
      guard = 0;
      while (!(instr_valid && icache_stall) && guard < 30) begin
         applyStimulus(1'b0, 1'b0, 32'd0);
         guard++;
      end
      checkOutput("pre_async_valid", 32'(instr_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_valid", 32'(instr_valid), 32'd0);
      checkOutput("async_addr", icache_addr, 32'd0);
      checkOutput("async_count", fetch_count, 32'd0);
      checkOutput("async_instr_pc", instr_pc, 32'd0);
      resetDut();
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 32'd0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
